pacman_mover: RTL and testbench
===============================

# pacman_mover

Consumes the 3-bit direction code produced by the keyboard/button input block (0 stationary, 1 right, 2 left, 3 up, 4 down). It turns that code into Pacman's grid position, one cell per move tick. Each candidate cell is checked against a synchronous maze-wall memory before the move is committed. A requested turn is buffered and applied at the first tick where it is legal; until then Pacman keeps moving in his current direction. Sits between the input block and the VGA sprite renderer / collision logic.

## Interface
- GRID_W, 32, maze width in cells
- GRID_H, 24, maze height in cells
- START_X, 14, reset column
- START_Y, 17, reset row
- STEP_DIV, 1000000, clock cycles per move tick; must be ≥ 6
- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-low; clears all state immediately
- direction  in  3  direction code from the input block
- rd_wall  in  1  maze memory read data; 1 = wall; valid the cycle after rd_en
- rd_en  out  1  maze memory read strobe (registered)
- rd_x  out  $clog2(GRID_W)  read column (registered)
- rd_y  out  $clog2(GRID_H)  read row (registered)
- pos_x  out  $clog2(GRID_W)  current column
- pos_y  out  $clog2(GRID_H)  current row
- cur_dir  out  3  direction currently being travelled (0 = stopped)
- moved  out  1  one-cycle pulse on each position update
- blocked  out  1  high while the last tick produced no move

## Operation
- **Request latch (req_dir).** Loaded every cycle with `direction` when `direction` is 1–4. Code 0 leaves req_dir unchanged, so the last press is held. Codes 5–7 are ignored.
- **Tick counter.** Counts 0..STEP_DIV-1 and wraps. A tick is the cycle where the count equals STEP_DIV-1. A tick that arrives while the FSM is not in IDLE is dropped.
- **Target cell for direction d.**
  - Right: x+1; from GRID_W-1 it wraps to 0 (tunnel).
  - Left: x-1; from 0 it wraps to GRID_W-1.
  - Up: y-1. Down: y+1.
  - Moving up from y=0, or down from y=GRID_H-1, is blocked without issuing a read.
- **FSM states:** IDLE, CHK_REQ, WAIT_REQ, CHK_CUR, WAIT_CUR.
- **IDLE, on tick:**
  - req_dir≠0 → CHK_REQ.
  - Otherwise cur_dir≠0 → CHK_CUR.
  - Otherwise stay in IDLE and set blocked=1.
- **CHK_REQ.** rd_en=1, rd_x/rd_y = target(req_dir). Next state WAIT_REQ. If the target is a vertical edge, rd_en stays 0 and rd_wall is treated as 1.
- **WAIT_REQ:**
  - rd_wall=0 → pos ← target, cur_dir ← req_dir, moved=1, blocked=0; go to IDLE.
  - rd_wall=1 and (cur_dir=0 or cur_dir=req_dir) → cur_dir ← 0, blocked=1; go to IDLE.
  - Otherwise → CHK_CUR.
- **CHK_CUR / WAIT_CUR.** Same sequence using cur_dir.
  - Free → move, cur_dir unchanged, blocked=0.
  - Wall → cur_dir ← 0, blocked=1.
  - Either way, go to IDLE.
- req_dir is never cleared by a blocked check. The turn stays queued until it becomes legal or is overwritten.
- rd_en is high for exactly one cycle per check and is 0 in all other states.

## Timing
- **Reset values:** pos_x=START_X, pos_y=START_Y, cur_dir=0, req_dir=0, moved=0, blocked=0, rd_en=0, rd_x=0, rd_y=0, counter=0, state IDLE.
- **Reset asserted mid-sequence:** all state returns to the reset values asynchronously. No pending read is honoured after reset is released.
- **Requested direction free.** With the tick sampled at edge E0:
  - rd_en is high during E0→E1.
  - rd_wall is sampled at E2.
  - pos/cur_dir update and the moved pulse occur at E2.
  - Latency is 2 cycles.
- **Fallback to cur_dir.** Second read during E2→E3, sampled at E4; pos updates at E4. Latency is 4 cycles.
- **Minimum STEP_DIV.** STEP_DIV ≥ 6 guarantees the FSM is back in IDLE before the next tick, so no ticks are lost in normal use.
- **Direction change during a check sequence.** It updates req_dir but does not alter the read already issued. The new value is used at the next tick.
- moved is high for exactly one cycle. blocked holds its value until the next decision.

## Test plan
- **Straight move.** Reset with START=(14,17), hold direction=1, memory all free, STEP_DIV=6 → pos_x steps 15, 16, 17 at 2 cycles after each tick; moved pulses once per tick; cur_dir=1.
- **Buffered turn.** Moving right, set direction=3, wall above cells x=15..16, free above x=17 → pos advances along x with two reads per tick. At x=17 the turn is taken: y=16, cur_dir=3, no further fallback reads.
- **Dead stop.** Moving right with the next cell a wall and req_dir=1 → blocked=1, cur_dir=0, pos unchanged. After the wall is cleared, the next tick moves and blocked=0.
- **Tunnel wrap and vertical edge.** From x=31 moving right → x=0 with rd_x=0. At y=0 pressing up → no rd_en for that check; falls back to cur_dir.
- **Idle start and reset.** After reset with direction=0 → no rd_en ever and blocked=1 after the first tick. Asserting reset during WAIT_CUR → outputs return to the reset values immediately and rd_en=0.

Source files
------------

// File: rtl/pacman_mover.sv
// pacman_mover: turns direction codes into wall-checked grid moves of Pacman, one cell per tick
module pacman_mover #(
   parameter int GRID_W   = 32,
   parameter int GRID_H   = 24,
   parameter int START_X  = 14,
   parameter int START_Y  = 17,
   parameter int STEP_DIV = 1000000,
   localparam int XW = $clog2(GRID_W),
   localparam int YW = $clog2(GRID_H),
   localparam int CW = $clog2(STEP_DIV)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic [2:0]    direction,
   input  logic          rd_wall,
   output logic          rd_en,
   output logic [XW-1:0] rd_x,
   output logic [YW-1:0] rd_y,
   output logic [XW-1:0] pos_x,
   output logic [YW-1:0] pos_y,
   output logic [2:0]    cur_dir,
   output logic          moved,
   output logic          blocked
);
   typedef enum logic [2:0] {IDLE, CHK_REQ, WAIT_REQ, CHK_CUR, WAIT_CUR} state_t;
   state_t state, state_n;
   logic [CW-1:0] cnt;
   logic [2:0] req_dir, chk_dir, idir;
   logic chk_edge, tick, issue, mv, stop, idle_blk, wall, tedge;
   logic [XW-1:0] tx;
   logic [YW-1:0] ty;
   assign tick  = cnt == CW'(STEP_DIV - 1);
   assign wall  = chk_edge | rd_wall;
   assign tx    = idir == 3'd1 ? (pos_x == XW'(GRID_W - 1) ? '0 : pos_x + XW'(1)) :
                  idir == 3'd2 ? (pos_x == '0 ? XW'(GRID_W - 1) : pos_x - XW'(1)) : pos_x;
   assign ty    = idir == 3'd3 ? pos_y - YW'(1) : idir == 3'd4 ? pos_y + YW'(1) : pos_y;
   assign tedge = (idir == 3'd3 && pos_y == '0) || (idir == 3'd4 && pos_y == YW'(GRID_H - 1));
   // state register
   always_ff @(posedge clk or negedge reset)
      if (!reset) state <= IDLE;
      else        state <= state_n;
   // next state and per-cycle decisions: which check to issue, move, or stop
   always_comb begin
      state_n  = state;
      issue    = 1'b0;
      idir     = req_dir;
      mv       = 1'b0;
      stop     = 1'b0;
      idle_blk = 1'b0;
      case (state)
         IDLE:
            if (tick) begin
               if (req_dir != 3'd0) begin
                  state_n = CHK_REQ;
                  issue   = 1'b1;
               end else if (cur_dir != 3'd0) begin
                  state_n = CHK_CUR;
                  issue   = 1'b1;
                  idir    = cur_dir;
               end else idle_blk = 1'b1;
            end
         CHK_REQ: state_n = WAIT_REQ;
         WAIT_REQ:
            if (!wall) begin
               mv      = 1'b1;
               state_n = IDLE;
            end else if (cur_dir == 3'd0 || cur_dir == chk_dir) begin
               stop    = 1'b1;
               state_n = IDLE;
            end else begin
               state_n = CHK_CUR;
               issue   = 1'b1;
               idir    = cur_dir;
            end
         CHK_CUR: state_n = WAIT_CUR;
         WAIT_CUR: begin
            state_n = IDLE;
            mv      = !wall;
            stop    = wall;
         end
         default: state_n = IDLE;
      endcase
   end
   // datapath: request latch, tick counter, read strobe, position and status
   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         req_dir  <= '0;
         cnt      <= '0;
         rd_en    <= 1'b0;
         rd_x     <= '0;
         rd_y     <= '0;
         chk_dir  <= '0;
         chk_edge <= 1'b0;
         pos_x    <= XW'(START_X);
         pos_y    <= YW'(START_Y);
         cur_dir  <= '0;
         moved    <= 1'b0;
         blocked  <= 1'b0;
      end else begin
         if (direction != 3'd0 && direction <= 3'd4) req_dir <= direction;
         cnt   <= tick ? '0 : cnt + CW'(1);
         rd_en <= issue && !tedge;
         moved <= mv;
         if (issue) begin
            rd_x     <= tx;
            rd_y     <= ty;
            chk_dir  <= idir;
            chk_edge <= tedge;
         end
         if (mv) begin
            pos_x   <= rd_x;
            pos_y   <= rd_y;
            cur_dir <= chk_dir;
            blocked <= 1'b0;
         end
         if (stop) begin
            cur_dir <= '0;
            blocked <= 1'b1;
         end
         if (idle_blk) blocked <= 1'b1;
      end
endmodule

// File: tb/tb_pacman_mover.sv
// tb_pacman_mover: scoreboard bench for pacman_mover with a synchronous maze-memory model
module tb_pacman_mover;
   logic clk = 1'b0;
   logic reset = 1'b0;
   logic [2:0] direction = 3'd0;
   logic rd_wall = 1'b0;
   logic rd_en, moved, blocked;
   logic [4:0] rd_x, rd_y, pos_x, pos_y;
   logic [2:0] cur_dir;
   bit walls [32][24];
   int cyc = 0;
   int n_chk = 0, n_fail = 0;
   int m_x, m_y, m_cur, m_req, m_blk;
   typedef struct {int x; int y; int cur; int blk; int reads; int mvi; int rx; int ry;} exp_t;
   exp_t sb[$];

   pacman_mover #(.GRID_W(32), .GRID_H(24), .START_X(14), .START_Y(17), .STEP_DIV(6)) dut (
      .clk(clk), .reset(reset), .direction(direction), .rd_wall(rd_wall), .rd_en(rd_en),
      .rd_x(rd_x), .rd_y(rd_y), .pos_x(pos_x), .pos_y(pos_y), .cur_dir(cur_dir),
      .moved(moved), .blocked(blocked));

   always #5 clk = ~clk;

   // maze memory: data valid the cycle after the strobe; garbage-free reads otherwise
   always @(posedge clk) rd_wall <= rd_en ? walls[rd_x][rd_y] : 1'b0;

   // edges since reset release; edge n is a tick when n % 6 == 0
   always @(posedge clk or negedge reset)
      if (!reset) cyc <= 0;
      else        cyc <= cyc + 1;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   function automatic void tgt(input int d, input int x, input int y, output int tx, output int ty, output bit ed);
      tx = d == 1 ? (x == 31 ? 0 : x + 1) : d == 2 ? (x == 0 ? 31 : x - 1) : x;
      ty = d == 3 ? y - 1 : d == 4 ? y + 1 : y;
      ed = (d == 3 && y == 0) || (d == 4 && y == 23);
   endfunction

   task automatic predict();
      exp_t e;
      int tx, ty, d;
      bit ed, w;
      e.reads = 0; e.mvi = -1; e.rx = -1; e.ry = -1;
      d = m_req != 0 ? m_req : m_cur;
      if (d != 0) begin
         tgt(d, m_x, m_y, tx, ty, ed);
         w = ed ? 1'b1 : walls[tx][ty];
         if (!ed) begin e.reads = 1; e.rx = tx; e.ry = ty; end
         if (!w) begin
            m_x = tx; m_y = ty; m_cur = d; m_blk = 0; e.mvi = 2;
         end else if (m_cur == 0 || m_cur == d) begin
            m_cur = 0; m_blk = 1;
         end else begin
            tgt(m_cur, m_x, m_y, tx, ty, ed);
            w = ed ? 1'b1 : walls[tx][ty];
            if (!ed) begin
               if (e.reads == 0) begin e.rx = tx; e.ry = ty; end
               e.reads++;
            end
            if (!w) begin m_x = tx; m_y = ty; m_blk = 0; e.mvi = 4; end
            else begin m_cur = 0; m_blk = 1; end
         end
      end else m_blk = 1;
      e.x = m_x; e.y = m_y; e.cur = m_cur; e.blk = m_blk;
      sb.push_back(e);
   endtask

   task automatic apply_reset();
      @(negedge clk);
      reset = 1'b0;
      direction = 3'd0;
      #1;
      m_x = 14; m_y = 17; m_cur = 0; m_req = 0; m_blk = 0;
      sb.delete();
   endtask

   task automatic release_reset();
      @(negedge clk);
      reset = 1'b1;
   endtask

   task automatic set_dir(input int d);
      direction = 3'(d);
      if (d >= 1 && d <= 4) m_req = d;
   endtask

   task automatic clear_walls();
      for (int i = 0; i < 32; i++)
         for (int j = 0; j < 24; j++) walls[i][j] = 1'b0;
   endtask

   // one move tick: push prediction, observe five cycles, pop and compare
   task automatic do_tick(input string tag);
      exp_t e;
      int reads, nmv, mvi, fx, fy;
      do @(negedge clk); while (cyc % 6 != 0);
      predict();
      reads = 0; nmv = 0; mvi = -1; fx = -1; fy = -1;
      for (int i = 0; i < 5; i++) begin
         if (i > 0) @(negedge clk);
         if (rd_en) begin
            if (reads == 0) begin fx = int'(rd_x); fy = int'(rd_y); end
            reads++;
         end
         if (moved) begin nmv++; mvi = i; end
      end
      e = sb.pop_front();
      n_chk++; if (int'(pos_x) != e.x) begin n_fail++; $display("FAIL %s pos_x: got %0d expected %0d", tag, pos_x, e.x); end
      n_chk++; if (int'(pos_y) != e.y) begin n_fail++; $display("FAIL %s pos_y: got %0d expected %0d", tag, pos_y, e.y); end
      n_chk++; if (int'(cur_dir) != e.cur) begin n_fail++; $display("FAIL %s cur_dir: got %0d expected %0d", tag, cur_dir, e.cur); end
      n_chk++; if (int'(blocked) != e.blk) begin n_fail++; $display("FAIL %s blocked: got %0d expected %0d", tag, blocked, e.blk); end
      n_chk++; if (reads != e.reads) begin n_fail++; $display("FAIL %s reads: got %0d expected %0d", tag, reads, e.reads); end
      n_chk++; if (mvi != e.mvi) begin n_fail++; $display("FAIL %s moved_cycle: got %0d expected %0d", tag, mvi, e.mvi); end
      n_chk++; if (nmv != (e.mvi >= 0 ? 1 : 0)) begin n_fail++; $display("FAIL %s moved_count: got %0d expected %0d", tag, nmv, e.mvi >= 0 ? 1 : 0); end
      if (e.reads > 0) begin
         n_chk++; if (fx != e.rx || fy != e.ry) begin n_fail++; $display("FAIL %s rd_xy: got (%0d,%0d) expected (%0d,%0d)", tag, fx, fy, e.rx, e.ry); end
      end
   endtask

   task automatic test_reset();
      apply_reset();
      n_chk++; if (pos_x !== 5'd14 || pos_y !== 5'd17) begin n_fail++; $display("FAIL reset pos: got (%0d,%0d) expected (14,17)", pos_x, pos_y); end
      n_chk++; if (cur_dir !== 3'd0 || moved !== 1'b0 || blocked !== 1'b0) begin n_fail++; $display("FAIL reset status: got cur=%0d mv=%0d blk=%0d expected 0 0 0", cur_dir, moved, blocked); end
      n_chk++; if (rd_en !== 1'b0 || rd_x !== 5'd0 || rd_y !== 5'd0) begin n_fail++; $display("FAIL reset read: got en=%0d x=%0d y=%0d expected 0 0 0", rd_en, rd_x, rd_y); end
      release_reset();
   endtask

   task automatic test_idle_start();
      apply_reset(); clear_walls(); release_reset();
      do_tick("idle1");
      do_tick("idle2");
   endtask

   task automatic test_straight();
      apply_reset(); clear_walls(); release_reset();
      set_dir(1);
      for (int i = 0; i < 3; i++) do_tick("straight");
   endtask

   task automatic test_turn();
      apply_reset(); clear_walls(); release_reset();
      set_dir(1);
      do_tick("turn_pre");
      walls[15][16] = 1'b1; walls[16][16] = 1'b1;
      set_dir(3);
      for (int i = 0; i < 4; i++) do_tick("turn");
   endtask

   task automatic test_dead_stop();
      apply_reset(); clear_walls(); release_reset();
      set_dir(1);
      do_tick("stop_pre");
      walls[16][17] = 1'b1;
      do_tick("stop1");
      do_tick("stop2");
      walls[16][17] = 1'b0;
      do_tick("stop_clear");
   endtask

   task automatic test_tunnel_edge();
      apply_reset(); clear_walls(); release_reset();
      set_dir(1);
      for (int i = 0; i < 18; i++) do_tick("tunnel_r");
      set_dir(3);
      for (int i = 0; i < 18; i++) do_tick("up_edge");
      set_dir(1);
      do_tick("edge_right");
      set_dir(3);
      do_tick("edge_fallback");
      apply_reset(); clear_walls(); release_reset();
      set_dir(2);
      for (int i = 0; i < 15; i++) do_tick("tunnel_l");
      set_dir(4);
      for (int i = 0; i < 8; i++) do_tick("down_edge");
   endtask

   task automatic test_reset_mid();
      apply_reset(); clear_walls(); release_reset();
      set_dir(1);
      do_tick("mid_pre");
      walls[15][16] = 1'b1;
      set_dir(3);
      do @(negedge clk); while (cyc % 6 != 0);
      repeat (3) @(negedge clk);
      reset = 1'b0;
      #1;
      n_chk++; if (pos_x !== 5'd14 || pos_y !== 5'd17) begin n_fail++; $display("FAIL mid_reset pos: got (%0d,%0d) expected (14,17)", pos_x, pos_y); end
      n_chk++; if (cur_dir !== 3'd0 || moved !== 1'b0 || blocked !== 1'b0) begin n_fail++; $display("FAIL mid_reset status: got cur=%0d mv=%0d blk=%0d expected 0 0 0", cur_dir, moved, blocked); end
      n_chk++; if (rd_en !== 1'b0 || rd_x !== 5'd0 || rd_y !== 5'd0) begin n_fail++; $display("FAIL mid_reset read: got en=%0d x=%0d y=%0d expected 0 0 0", rd_en, rd_x, rd_y); end
      direction = 3'd0;
      m_x = 14; m_y = 17; m_cur = 0; m_req = 0; m_blk = 0;
      sb.delete();
      release_reset();
      do_tick("after_reset");
   endtask

   initial begin
      test_reset();
      test_idle_start();
      test_straight();
      test_turn();
      test_dead_stop();
      test_tunnel_edge();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
